oam_dma: RTL

- CPU-side sprite DMA engine. Sits on the CPU bus directly upstream of the ppu register port.
- On a CPU write to $4014 it halts the CPU, then copies 256 bytes from CPU page {value,8'h00} into OAM through repeated writes to $2004.
- A top-level mux places its bus outputs in front of the ppu/mmap while dma_active is high.
- Runs in the clk_cpu domain.

---
 rtl/oam_dma_pkg.sv | 16 +
 rtl/oam_dma.sv | 137 +++++++++++++
 2 files changed

// File: rtl/oam_dma_pkg.sv
// Shared types and default bus addresses for the OAM sprite DMA engine.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
    localparam int          XFER_LEN_DEF      = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to the DMA register, halt the CPU and copy one
// page of CPU memory into OAM through alternating get/put bus cycles.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
    parameter int          XFER_LEN      = XFER_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  bus_data_i,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_data_o,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  state_q, state_d;
    logic        parity_q;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic        rdy_q, rdy_d;
    logic        active_q, active_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        trigger_s;

    assign trigger_s = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        page_d   = page_q;
        rdy_d    = rdy_q;
        active_d = 1'b0;
        addr_d   = 16'h0000;
        rw_d     = 1'b1;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    page_d  = cpu_data_i;
                    idx_d   = 8'h00;
                    state_d = HALT;
                    rdy_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                // The cycle after HALT has parity ~parity_q; reads must land on parity 0.
                if (parity_q) begin
                    state_d = READ;
                end else begin
                    state_d = ALIGN;
                end
                active_d = 1'b1;
                addr_d   = {page_q, idx_q};
            end
            ALIGN: begin
                state_d  = READ;
                active_d = 1'b1;
                addr_d   = {page_q, idx_q};
            end
            READ: begin
                state_d  = WRITE;
                active_d = 1'b1;
                rw_d     = 1'b0;
                addr_d   = OAM_DATA_ADDR;
                data_d   = bus_data_i;
            end
            WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rdy_d   = 1'b1;
                end else begin
                    state_d  = READ;
                    active_d = 1'b1;
                    addr_d   = {page_q, idx_q + 8'd1};
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State, counters and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            rdy_q    <= 1'b1;
            active_q <= 1'b0;
            addr_q   <= 16'h0000;
            rw_q     <= 1'b1;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            idx_q    <= idx_d;
            page_q   <= page_d;
            rdy_q    <= rdy_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign rdy        = rdy_q;
    assign dma_active = active_q;
    assign dma_addr   = addr_q;
    assign dma_rw     = rw_q;
    assign dma_data_o = data_q;
    assign done       = done_q;

endmodule
